// File: rtl/memoria_data_be.sv
// -----------------------------------------------------------------------------
// memoria_data_be
//   Byte-banked synchronous data memory for the pipeline MEM stage.
//   RV32-style sized stores (SB/SH/SW) and loads (LB/LBU/LH/LHU/LW).
//   Stores use byte enables and left-rotate their data into the addressed lanes.
//   Loads shift the addressed lanes back down and then sign- or zero-extend them.
//   Read and write ports are independent, and a read has one registered cycle of
//   latency. A same-cycle write to the row being read is forwarded write-first.
//   Misaligned accesses are flagged and counted in a saturating counter.
//
// Ports
//   Clk        in   clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   rd_en      in   read request
//   raddress   in   read byte address (bits above ADDR_W ignored)
//   rsize      in   0=byte 1=half 2/3=word
//   runsigned  in   1: zero-extend, 0: sign-extend sub-word loads
//   wr_en      in   write request
//   waddress   in   write byte address (bits above ADDR_W ignored)
//   wsize      in   0=byte 1=half 2/3=word
//   Datain     in   right-aligned store data
//   Dataout    out  extended load data, valid with rvalid
//   rvalid     out  load result valid (one cycle after rd_en)
//   rerr       out  load was misaligned (qualified with rvalid)
//   werr       out  one-cycle pulse: previous write was misaligned and dropped
//   err_cnt    out  saturating count of misaligned reads + writes
// -----------------------------------------------------------------------------
module memoria_data_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int ERR_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              rd_en,
    input  logic [31:0]       raddress,
    input  logic [1:0]        rsize,
    input  logic              runsigned,
    input  logic              wr_en,
    input  logic [31:0]       waddress,
    input  logic [1:0]        wsize,
    input  logic [DATA_W-1:0] Datain,
    output logic [DATA_W-1:0] Dataout,
    output logic              rvalid,
    output logic              rerr,
    output logic              werr,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int NL   = DATA_W / 8;
    localparam int LB   = $clog2(NL);
    localparam int RW   = ADDR_W - LB;
    localparam int ROWS = 1 << RW;

    // Address bits above ADDR_W alias onto the same locations.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{raddress[31:ADDR_W], waddress[31:ADDR_W]};

    function automatic logic is_aligned(input logic [LB-1:0] lane, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return ~lane[0];
            default: return lane == '0;
        endcase
    endfunction

    function automatic logic [NL-1:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return NL'(1);
            2'd1:    return NL'(3);
            default: return '1;
        endcase
    endfunction

    // ---------------------------------------------------------------- decode
    logic [LB-1:0]       rlane, wlane;
    logic [RW-1:0]       rrow, wrow;
    logic                raligned, waligned;
    logic                rd_go, wr_go, same_row;
    logic [NL-1:0]       wbe;
    logic [2*DATA_W-1:0] wdata_dbl;
    logic [DATA_W-1:0]   wdata_rot;

    assign rlane    = raddress[LB-1:0];
    assign wlane    = waddress[LB-1:0];
    assign rrow     = raddress[ADDR_W-1:LB];
    assign wrow     = waddress[ADDR_W-1:LB];
    assign raligned = is_aligned(rlane, rsize);
    assign waligned = is_aligned(wlane, wsize);
    assign rd_go    = rd_en & raligned;
    assign wr_go    = wr_en & waligned;
    assign same_row = rrow == wrow;
    assign wbe      = size_mask(wsize) << wlane;

    // Rotate left by 8*lane: the upper half of the doubled word shifted left.
    assign wdata_dbl = {Datain, Datain} << {wlane, 3'b000};
    assign wdata_rot = wdata_dbl[2*DATA_W-1:DATA_W];

    // ---------------------------------------------------------------- banks
    logic [DATA_W-1:0] rd_word;

    for (genvar l = 0; l < NL; l++) begin : g_bank
        logic [7:0] mem [ROWS];
        logic [7:0] rd_q;

        // NOTE: the storage array has no reset; clearing it would force flops instead of RAM.
        always_ff @(posedge Clk) begin
            if (wr_go && wbe[l]) begin
                mem[wrow] <= wdata_rot[8*l +: 8];
            end
        end

        // Write-first: a lane written in the same cycle returns the new store byte.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                rd_q <= '0;
            end else if (rd_go) begin
                if (wr_go && wbe[l] && same_row) begin
                    rd_q <= wdata_rot[8*l +: 8];
                end else begin
                    rd_q <= mem[rrow];
                end
            end
        end

        assign rd_word[8*l +: 8] = rd_q;
    end

    // ---------------------------------------------------------------- read control
    logic [LB-1:0] lane_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          zero_q;   // forces Dataout to 0 after reset or a misaligned read

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rvalid <= 1'b0;
            rerr   <= 1'b0;
            werr   <= 1'b0;
            zero_q <= 1'b1;
            lane_q <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
        end else begin
            rvalid <= rd_en;
            rerr   <= rd_en & ~raligned;
            werr   <= wr_en & ~waligned;
            // Lane/size state only moves on a request, so Dataout holds between reads.
            if (rd_en) begin
                zero_q <= ~raligned;
                lane_q <= rlane;
                size_q <= rsize;
                uns_q  <= runsigned;
            end
        end
    end

    // ---------------------------------------------------------------- error counter
    logic [1:0]     err_inc;
    logic [ERR_W:0] err_sum;

    assign err_inc = 2'(rd_en & ~raligned) + 2'(wr_en & ~waligned);
    assign err_sum = {1'b0, err_cnt} + (ERR_W + 1)'(err_inc);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_cnt <= '0;
        end else if (err_sum[ERR_W]) begin
            err_cnt <= '1;
        end else begin
            err_cnt <= err_sum[ERR_W-1:0];
        end
    end

    // ---------------------------------------------------------------- load formatting
    logic [DATA_W-1:0] shifted;
    assign shifted = rd_word >> {lane_q, 3'b000};

    // NOTE: Dataout gets a default first so no path through this block infers a latch.
    always_comb begin
        Dataout = shifted;
        if (zero_q) begin
            Dataout = '0;
        end else begin
            case (size_q)
                2'd0:    Dataout = {{(DATA_W-8){~uns_q & shifted[7]}}, shifted[7:0]};
                2'd1:    Dataout = {{(DATA_W-16){~uns_q & shifted[15]}}, shifted[15:0]};
                default: Dataout = shifted;
            endcase
        end
    end

endmodule
